store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Small in-order FIFO of pending word stores between the MEM-stage store path and the single-ported data memory.
- Lets a store retire in one cycle even when the memory port is taken by a load. Entries drain to memory one per cycle whenever the port is free.
- Load addresses are checked against pending entries so a load never reads stale memory.

Parameters:
DEPTH, 4, number of buffer entries; power of 2, minimum 2
AW, 32, address width
DW, 32, data width (one word per entry)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset; asynchronous, active-low
st_valid_i  input  1  store request this cycle
st_addr_i  input  AW  store byte address, word-aligned
st_data_i  input  DW  store data
st_ready_o  output  1  buffer can accept a store
ld_valid_i  input  1  load presented to data memory this cycle; memory port busy
ld_addr_i  input  AW  load byte address
ld_hit_o  output  1  load matched a pending entry; use ld_data_o
ld_data_o  output  DW  forwarded store data
ld_stall_o  output  1  load must be held; retry next cycle
mem_wr_o  output  1  write strobe to data memory (MemWr)
mem_adr_o  output  AW  write address to data memory
mem_data_o  output  DW  write data to data memory
count_o  output  log2(DEPTH)+1  current occupancy
empty_o  output  1  occupancy == 0

Behaviour:
- Storage: circular FIFO with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- Reset (rst_i low, asynchronous): pointers = 0, count = 0. Entry contents are don't-care.
  - Outputs during reset: st_ready_o=1, empty_o=1, count_o=0, mem_wr_o=0, ld_hit_o=0, ld_stall_o=0, ld_data_o=0.
  - mem_adr_o and mem_data_o are 0 while empty.
  - Reset mid-drain discards all pending stores; the memory write in flight that cycle is still committed only if the clock edge precedes reset assertion.
- Push:
  - st_ready_o = (count != DEPTH). No full-bypass; a full buffer refuses even if a pop occurs that cycle.
  - push = st_valid_i & st_ready_o. The entry is written at wr_ptr and wr_ptr increments.
  - st_valid_i while full is ignored; upstream holds the request.
- Drain:
  - mem_wr_o = !empty & !ld_valid_i. Combinational.
  - mem_adr_o and mem_data_o = entry at rd_ptr (0 when empty).
  - pop = mem_wr_o. rd_ptr increments at the same edge on which data memory captures the write.
- Latency: a store pushed at edge N is earliest on mem_wr_o during cycle N+1. It is never written in its push cycle.
- Simultaneous push and pop: count unchanged. Push-only: +1. Pop-only: -1.
- Load ordering: a load always has priority on the memory port. Stores drain only on load-free cycles.
- Match rule: an entry matches when entry addr[AW-1:2] == ld_addr_i[AW-1:2] and the entry is valid.
  - The entry being popped this cycle still counts.
  - A store being pushed this cycle does not.
- Multiple matches: the youngest entry (closest to wr_ptr) wins.
- ld_* outputs are 0 when ld_valid_i=0.
- Starvation: a continuous load stream blocks draining. Upstream guarantees a load-free cycle eventually; no internal timeout.

Optional Feature:
STORE_BUFFER_FWD_EN
- Defined: on a match, ld_hit_o=1 and ld_data_o = data of the youngest matching entry, both combinational in the same cycle. ld_stall_o is constant 0.
- Undefined: ld_hit_o=0 and ld_data_o=0 always. ld_stall_o=1 while ld_valid_i and any entry matches.
  - Because a stalled load still holds ld_valid_i, it blocks draining.
  - Therefore, when undefined, mem_wr_o = !empty & (!ld_valid_i | ld_stall_o). A stalled load does not occupy the port, so the buffer drains until the match clears.

Test Plan:
- Reset then idle -> empty_o=1, count_o=0, st_ready_o=1, mem_wr_o=0. Reset asserted with 3 entries pending -> count_o=0 immediately (asynchronous), no further mem_wr_o.
- Push 0x10/0xDEADBEEF with ld_valid_i=0 -> next cycle mem_wr_o=1, mem_adr_o=0x10, mem_data_o=0xDEADBEEF. The cycle after, empty_o=1.
- Hold ld_valid_i=1 (addr 0x40) and push 5 stores (DEPTH=4) -> st_ready_o=0 after the 4th push, the 5th is held, mem_wr_o=0 throughout. Drop ld_valid_i -> four writes in order, one per cycle, then the 5th is accepted.
- FWD_EN: push 0x20/0x11111111 then 0x20/0x22222222 while loads block the port; load 0x20 -> ld_hit_o=1, ld_data_o=0x22222222. Load 0x24 -> ld_hit_o=0.
- No FWD_EN: pending 0x20 entry, load 0x20 -> ld_stall_o=1, and the entry drains that cycle (mem_wr_o=1). Next cycle ld_stall_o=0.
- Simultaneous push and pop at count=2 -> count stays 2. Pointer wrap after 9 push/pop pairs leaves FIFO order intact (addresses written in issue order).

Source files
------------

// File: rtl/store_buffer_if.sv
// Store buffer bus: store request path, load probe path, memory write port
// and occupancy status, grouped so the pipeline side and the buffer share one bundle.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid_i;
  logic [AW-1:0] st_addr_i;
  logic [DW-1:0] st_data_i;
  logic          st_ready_o;

  logic          ld_valid_i;
  logic [AW-1:0] ld_addr_i;
  logic          ld_hit_o;
  logic [DW-1:0] ld_data_o;
  logic          ld_stall_o;

  logic          mem_wr_o;
  logic [AW-1:0] mem_adr_o;
  logic [DW-1:0] mem_data_o;

  logic [CW-1:0] count_o;
  logic          empty_o;

  modport master (
    output st_valid_i, st_addr_i, st_data_i, ld_valid_i, ld_addr_i,
    input  st_ready_o, ld_hit_o, ld_data_o, ld_stall_o,
    input  mem_wr_o, mem_adr_o, mem_data_o, count_o, empty_o
  );

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, ld_valid_i, ld_addr_i,
    output st_ready_o, ld_hit_o, ld_data_o, ld_stall_o,
    output mem_wr_o, mem_adr_o, mem_data_o, count_o, empty_o
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM-stage store path and the single-ported
// data memory. Stores retire into a circular FIFO and drain one per load-free
// cycle; loads are checked against pending entries.
// Optional macro STORE_BUFFER_FWD_EN: forward the youngest matching store to a
// load in the same cycle. Without it a matching load stalls while the buffer
// drains until the match clears.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          match_any;
  logic [DW-1:0] match_data;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign push  = bus.st_valid_i & ~full;
  assign pop   = bus.mem_wr_o;

  // Walk entries oldest to youngest so the last match seen is the youngest;
  // an entry being pushed this cycle is not yet counted.
  always_comb begin
    logic [PW-1:0] idx;
    match_any  = 1'b0;
    match_data = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (addr_q[idx][AW-1:2] == bus.ld_addr_i[AW-1:2])) begin
        match_any  = 1'b1;
        match_data = data_q[idx];
      end
    end
  end

  // Load response and memory-port arbitration; loads always own the port
  // unless they are being held for a pending store.
  always_comb begin
`ifdef STORE_BUFFER_FWD_EN
    bus.ld_hit_o   = bus.ld_valid_i & match_any;
    bus.ld_data_o  = (bus.ld_valid_i & match_any) ? match_data : '0;
    bus.ld_stall_o = 1'b0;
    bus.mem_wr_o   = ~empty & ~bus.ld_valid_i;
`else
    bus.ld_hit_o   = 1'b0;
    bus.ld_data_o  = '0;
    bus.ld_stall_o = bus.ld_valid_i & match_any;
    bus.mem_wr_o   = ~empty & (~bus.ld_valid_i | bus.ld_stall_o);
`endif
  end

  assign bus.st_ready_o = ~full;
  assign bus.mem_adr_o  = empty ? '0 : addr_q[rd_ptr];
  assign bus.mem_data_o = empty ? '0 : data_q[rd_ptr];
  assign bus.count_o    = count;
  assign bus.empty_o    = empty;

  // Pointer and occupancy bookkeeping; reset discards everything pending.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr] <= bus.st_addr_i;
      data_q[wr_ptr] <= bus.st_data_i;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer. A queue model of pending stores serves
// as the scoreboard: entries are pushed when a store is accepted and popped and
// compared when the buffer writes to memory. Load responses follow from the
// same queue, depending on STORE_BUFFER_FWD_EN.
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  ent_t sb[$];

  store_buffer_if #(.DEPTH(DEPTH), .AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model, then advance the model.
  task automatic check_cycle();
    logic        exp_ready, hit, e_hit, e_stall, e_wr;
    logic [31:0] hd, e_data;
    chk("count", 32'(bus.count_o), 32'(sb.size()));
    chk("empty", 32'(bus.empty_o), 32'(sb.size() == 0));
    exp_ready = (sb.size() != DEPTH);
    chk("st_ready", 32'(bus.st_ready_o), 32'(exp_ready));
    hit = 1'b0;
    hd  = '0;
    foreach (sb[i]) begin
      if (sb[i].addr[31:2] == bus.ld_addr_i[31:2]) begin
        hit = 1'b1;
        hd  = sb[i].data;
      end
    end
`ifdef STORE_BUFFER_FWD_EN
    e_hit   = bus.ld_valid_i & hit;
    e_data  = e_hit ? hd : 32'h0;
    e_stall = 1'b0;
    e_wr    = (sb.size() != 0) && !bus.ld_valid_i;
`else
    e_hit   = 1'b0;
    e_data  = 32'h0;
    e_stall = bus.ld_valid_i & hit;
    e_wr    = (sb.size() != 0) && (!bus.ld_valid_i || e_stall);
`endif
    chk("ld_hit", 32'(bus.ld_hit_o), 32'(e_hit));
    chk("ld_data", bus.ld_data_o, e_data);
    chk("ld_stall", 32'(bus.ld_stall_o), 32'(e_stall));
    chk("mem_wr", 32'(bus.mem_wr_o), 32'(e_wr));
    if (e_wr) begin
      chk("mem_adr", bus.mem_adr_o, sb[0].addr);
      chk("mem_data", bus.mem_data_o, sb[0].data);
    end else if (sb.size() == 0) begin
      chk("mem_adr_empty", bus.mem_adr_o, 32'h0);
      chk("mem_data_empty", bus.mem_data_o, 32'h0);
    end
    if (e_wr) void'(sb.pop_front());
    if (bus.st_valid_i && exp_ready) sb.push_back('{addr: bus.st_addr_i, data: bus.st_data_i});
  endtask

  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [31:0] la);
    bus.st_valid_i = sv;
    bus.st_addr_i  = sa;
    bus.st_data_i  = sd;
    bus.ld_valid_i = lv;
    bus.ld_addr_i  = la;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    bus.st_valid_i = 1'b0;
    bus.st_addr_i  = '0;
    bus.st_data_i  = '0;
    bus.ld_valid_i = 1'b0;
    bus.ld_addr_i  = '0;

    // Outputs while held in reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(bus.empty_o), 32'h1);
    chk("rst_count", 32'(bus.count_o), 32'h0);
    chk("rst_ready", 32'(bus.st_ready_o), 32'h1);
    chk("rst_mem_wr", 32'(bus.mem_wr_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Single store drains the cycle after it is pushed
    step(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("first_wr", 32'(bus.mem_wr_o), 32'h1);
    chk("first_adr", bus.mem_adr_o, 32'h10);
    chk("first_data", bus.mem_data_o, 32'hDEADBEEF);
    idle(2);

    // Fill behind a blocking load stream, fifth store held until space frees
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 32'h40);
    chk("full_ready", 32'(bus.st_ready_o), 32'h0);
    chk("full_count", 32'(bus.count_o), 32'h4);
    while (sb.size() < DEPTH || bus.st_ready_o == 1'b0) begin
      step(1'b1, 32'h110, 32'hA000_0004, 1'b0, 32'h0);
      if (sb.size() > 0 && sb[sb.size()-1].addr == 32'h110) break;
    end
    idle(6);

    // Two stores to one word, then loads to that word and a neighbour
    step(1'b1, 32'h20, 32'h11111111, 1'b1, 32'h40);
    step(1'b1, 32'h20, 32'h22222222, 1'b1, 32'h40);
`ifdef STORE_BUFFER_FWD_EN
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = 32'h20;
    #1;
    chk("fwd_hit", 32'(bus.ld_hit_o), 32'h1);
    chk("fwd_data", bus.ld_data_o, 32'h22222222);
`endif
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h24);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    idle(4);

    // Steady push+pop at occupancy 2 across pointer wrap
    step(1'b1, 32'h300, 32'hB0, 1'b1, 32'h40);
    step(1'b1, 32'h304, 32'hB1, 1'b1, 32'h40);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 32'h308 + 32'(i * 4), 32'hB2 + 32'(i), 1'b0, 32'h0);
      chk("pair_count", 32'(bus.count_o), 32'h2);
    end
    idle(4);

    // Asynchronous reset with three stores pending
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h200 + 32'(i * 4), 32'hC0 + 32'(i), 1'b1, 32'h40);
    bus.st_valid_i = 1'b0;
    bus.ld_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_count", 32'(bus.count_o), 32'h0);
    chk("arst_empty", 32'(bus.empty_o), 32'h1);
    chk("arst_mem_wr", 32'(bus.mem_wr_o), 32'h0);
    chk("arst_ready", 32'(bus.st_ready_o), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);

    // Random mix over a small address window to exercise matching
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 32'h20 + 32'($urandom_range(0, 3) * 4), $urandom,
           ($urandom_range(0, 2) == 0), 32'h20 + 32'($urandom_range(0, 4) * 4));
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk("final_empty", 32'(bus.empty_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
